// File: rtl/l2_bus_arbiter_pkg.sv
// Shared types for the L2 bus arbiter slice.
//   mem_bus_req_t  : L1 -> L2 request (load/store strobes, address, write data)
//   mem_bus_resp_t : L2 -> L1 response (ready pulse, read data)
//   arb_owner_t    : which master owns (or last owned) the L2 port
//   arb_state_t    : arbiter FSM states
//   req_active()   : a request is active when it asks for a load or a store
package l2_bus_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic                  mem_req_load;
        logic                  mem_req_store;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data_out;
    } mem_bus_req_t;

    typedef struct packed {
        logic                  mem_ready;
        logic [MEM_DATA_W-1:0] mem_data;
    } mem_bus_resp_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    function automatic logic req_active(input mem_bus_req_t r);
        return r.mem_req_load | r.mem_req_store;
    endfunction

endpackage

// File: rtl/l2_bus_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick.
// Ports:
//   act_i, act_d : request-active bits of master 0 (I) and master 1 (D)
//   last_owner   : master that held the port most recently (0 = I, 1 = D)
//   winner       : chosen master (0 = I, 1 = D); holds last_owner when nobody asks
//   valid        : at least one master is active
module l2_bus_arbiter_rr_pick2
    import l2_bus_arbiter_pkg::*;
(
    input  logic act_i,
    input  logic act_d,
    input  logic last_owner,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid = act_i | act_d;
        if (act_i && act_d) begin
            // Contention: the master that did not go last wins.
            winner = ~last_owner;
        end else if (act_d) begin
            winner = OWNER_D;
        end else if (act_i) begin
            winner = OWNER_I;
        end else begin
            winner = last_owner;
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Shares the single L2 port between the instruction-side and data-side L1 caches.
// One grant covers a whole transaction: it is held until L2 pulses mem_ready (or the
// owner withdraws its request), followed by a one-cycle RELEASE in which nothing is
// forwarded so the owner's registered request drop becomes visible.
//
// Optional build macro: ARB_STATS_EN adds saturating statistics counters and ports.
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   req_i / resp_i    : I-side L1 request in / response out
//   req_d / resp_d    : D-side L1 request in / response out
//   req_l2 / resp_l2  : request out to L2 / response in from L2
//   busy              : high in GRANT or RELEASE
//   owner             : current or last owner (0 = I, 1 = D)
//   stat_grants_i/_d  : grants per master            (ARB_STATS_EN only)
//   stat_wait         : cycles a non-owner waited    (ARB_STATS_EN only)
//   state_dbg         : FSM state (arb_state_t encoding) for observation
//
// Handshake: a master is active while mem_req_load | mem_req_store is high and keeps
// its request stable until it sees mem_ready; mem_ready is a one-cycle pulse from L2,
// forwarded combinationally to the owner only, and only in GRANT.
module l2_bus_arbiter
    import l2_bus_arbiter_pkg::*;
#(
    parameter logic RESET_PRIO = 1'b1,
    parameter int   STAT_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  mem_bus_req_t  req_i,
    output mem_bus_resp_t resp_i,
    input  mem_bus_req_t  req_d,
    output mem_bus_resp_t resp_d,
    output mem_bus_req_t  req_l2,
    input  mem_bus_resp_t resp_l2,
    output logic          busy,
    output logic          owner,
`ifdef ARB_STATS_EN
    output logic [STAT_WIDTH-1:0] stat_grants_i,
    output logic [STAT_WIDTH-1:0] stat_grants_d,
    output logic [STAT_WIDTH-1:0] stat_wait,
`endif
    output logic [1:0]    state_dbg
);

    localparam logic [1:0] S_IDLE    = ARB_IDLE;
    localparam logic [1:0] S_GRANT   = ARB_GRANT;
    localparam logic [1:0] S_RELEASE = ARB_RELEASE;

    logic [1:0]   state_q, state_d;
    logic         owner_q, owner_d;
    logic         act_i, act_d;
    logic         pick_winner, pick_valid;
    logic         in_grant;
    logic         owner_act;
    mem_bus_req_t owner_req;

    assign act_i     = req_active(req_i);
    assign act_d     = req_active(req_d);
    assign owner_req = (owner_q == OWNER_D) ? req_d : req_i;
    assign owner_act = req_active(owner_req);
    assign in_grant  = (state_q == S_GRANT);

    l2_bus_arbiter_rr_pick2 u_pick (
        .act_i      (act_i),
        .act_d      (act_d),
        .last_owner (owner_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Ready ends the transaction; a withdrawn request abandons it.
                if (resp_l2.mem_ready || !owner_act) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= ~RESET_PRIO;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Only GRANT forwards anything; IDLE and RELEASE present an all-zero request.
    always_comb begin
        req_l2 = '0;
        if (in_grant) begin
            req_l2 = owner_req;
        end
        resp_i.mem_data  = resp_l2.mem_data;
        resp_d.mem_data  = resp_l2.mem_data;
        resp_i.mem_ready = in_grant && (owner_q == OWNER_I) && resp_l2.mem_ready;
        resp_d.mem_ready = in_grant && (owner_q == OWNER_D) && resp_l2.mem_ready;
    end

    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;
    assign state_dbg = state_q;

`ifdef ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grants_i_q, grants_i_d;
    logic [STAT_WIDTH-1:0] grants_d_q, grants_d_d;
    logic [STAT_WIDTH-1:0] wait_q, wait_d;
    logic                  non_owner_act;

    assign non_owner_act = (owner_q == OWNER_D) ? act_i : act_d;

    // All counters saturate at all-ones instead of wrapping.
    always_comb begin
        grants_i_d = grants_i_q;
        grants_d_d = grants_d_q;
        wait_d     = wait_q;
        if ((state_q == S_IDLE) && pick_valid) begin
            if (pick_winner == OWNER_D) begin
                if (grants_d_q != '1) grants_d_d = grants_d_q + 1'b1;
            end else begin
                if (grants_i_q != '1) grants_i_d = grants_i_q + 1'b1;
            end
        end
        if (busy && non_owner_act && (wait_q != '1)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grants_i_q <= '0;
            grants_d_q <= '0;
            wait_q     <= '0;
        end else begin
            grants_i_q <= grants_i_d;
            grants_d_q <= grants_d_d;
            wait_q     <= wait_d;
        end
    end

    assign stat_grants_i = grants_i_q;
    assign stat_grants_d = grants_d_q;
    assign stat_wait     = wait_q;
`else
    // Counters are compiled out; the width parameter only has to be sane.
    if (STAT_WIDTH < 1) begin : g_stat_width_unused
    end
`endif

    // Load and store together is illegal on this bus; it is forwarded unchanged.
    a_no_load_and_store: assert property (@(posedge clock) disable iff (reset)
        in_grant |-> !(owner_req.mem_req_load && owner_req.mem_req_store));

endmodule

// File: tb/tb_l2_bus_arbiter.sv
module tb_l2_bus_arbiter;
  import l2_bus_arbiter_pkg::*;

  localparam logic TB_RESET_PRIO = 1'b1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  mem_bus_req_t  req_i = '0, req_d = '0, req_l2;
  mem_bus_resp_t resp_i, resp_d, resp_l2 = '0;
  logic          busy, owner;
  logic [1:0]    state_dbg;
`ifdef ARB_STATS_EN
  logic [31:0]   stat_grants_i, stat_grants_d, stat_wait;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  l2_bus_arbiter #(.RESET_PRIO(TB_RESET_PRIO), .STAT_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req_i(req_i), .resp_i(resp_i),
    .req_d(req_d), .resp_d(resp_d),
    .req_l2(req_l2), .resp_l2(resp_l2),
    .busy(busy), .owner(owner),
`ifdef ARB_STATS_EN
    .stat_grants_i(stat_grants_i), .stat_grants_d(stat_grants_d), .stat_wait(stat_wait),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic mem_bus_req_t mk_req(input int op, input logic [31:0] addr, input logic [31:0] data);
    mem_bus_req_t r;
    r = '0;
    r.mem_req_load  = (op == 1);
    r.mem_req_store = (op == 2);
    r.addr = addr;
    r.data_out = data;
    return r;
  endfunction

  task automatic do_reset();
    tick();
    reset = 1'b1;
    req_i = '0;
    req_d = '0;
    resp_l2 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    req_i = '0;
    req_d = '0;
    resp_l2 = '0;
    repeat (4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    resp_l2.mem_ready = 1'b1;
    resp_l2.mem_data = 32'hA5A5_0001;
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (owner !== ~TB_RESET_PRIO) begin bad++; $display("FAIL rst_owner got=%0b exp=%0b", owner, ~TB_RESET_PRIO); end
    total++; if (req_l2 !== '0) begin bad++; $display("FAIL rst_req_l2 got=%h exp=0", req_l2); end
    total++; if (resp_i.mem_ready !== 1'b0 || resp_d.mem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_leak got=%0b%0b exp=00", resp_i.mem_ready, resp_d.mem_ready); end
    total++; if (resp_i.mem_data !== 32'hA5A5_0001 || resp_d.mem_data !== 32'hA5A5_0001) begin bad++; $display("FAIL rst_mem_data got=%h/%h exp=a5a50001", resp_i.mem_data, resp_d.mem_data); end
`ifdef ARB_STATS_EN
    total++; if (stat_grants_i !== 0 || stat_grants_d !== 0 || stat_wait !== 0) begin bad++; $display("FAIL rst_stats got=%0d/%0d/%0d exp=0/0/0", stat_grants_i, stat_grants_d, stat_wait); end
`endif
    resp_l2 = '0;
  endtask

  // Only D loads 0x40; L2 answers in the third grant cycle.
  task automatic test_single_d();
    do_reset();
    req_d = mk_req(1, 32'h40, 32'h0);
    @(negedge clock);
    total++; if (req_l2.mem_req_load !== 1'b0) begin bad++; $display("FAIL single_lat0 got=%0b exp=0", req_l2.mem_req_load); end
    tick();
    @(negedge clock);
    total++; if (req_l2.mem_req_load !== 1'b1 || req_l2.addr !== 32'h40) begin bad++; $display("FAIL single_fwd got=%0b/%h exp=1/40", req_l2.mem_req_load, req_l2.addr); end
    total++; if (busy !== 1'b1 || owner !== 1'b1) begin bad++; $display("FAIL single_owner got=%0b/%0b exp=1/1", busy, owner); end
    tick();
    tick();
    resp_l2.mem_ready = 1'b1;
    @(negedge clock);
    total++; if (resp_d.mem_ready !== 1'b1) begin bad++; $display("FAIL single_ready_d got=%0b exp=1", resp_d.mem_ready); end
    total++; if (resp_i.mem_ready !== 1'b0) begin bad++; $display("FAIL single_ready_i got=%0b exp=0", resp_i.mem_ready); end
    tick();
    resp_l2.mem_ready = 1'b0;
    req_d = '0;
    @(negedge clock);
    total++; if (busy !== 1'b1 || req_l2.mem_req_load !== 1'b0) begin bad++; $display("FAIL single_release got=%0b/%0b exp=1/0", busy, req_l2.mem_req_load); end
    tick();
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_free got=%0b exp=0", busy); end
    drain();
  endtask

  // I and D together right after reset: D first, then I.
  task automatic test_contention();
    do_reset();
    req_i = mk_req(1, 32'h100, 32'h0);
    req_d = mk_req(1, 32'h200, 32'h0);
    tick();
    @(negedge clock);
    total++; if (owner !== 1'b1 || req_l2.addr !== 32'h200) begin bad++; $display("FAIL cont_first got=%0b/%h exp=1/200", owner, req_l2.addr); end
    resp_l2.mem_ready = 1'b1;
    #1;
    total++; if (resp_d.mem_ready !== 1'b1 || resp_i.mem_ready !== 1'b0) begin bad++; $display("FAIL cont_ready1 got=%0b%0b exp=01", resp_i.mem_ready, resp_d.mem_ready); end
    tick();
    resp_l2.mem_ready = 1'b0;
    req_d = '0;
    tick();
    @(negedge clock);
    total++; if (busy !== 1'b0 || owner !== 1'b1) begin bad++; $display("FAIL cont_idle got=%0b/%0b exp=0/1", busy, owner); end
    tick();
    @(negedge clock);
    total++; if (busy !== 1'b1 || owner !== 1'b0 || req_l2.addr !== 32'h100) begin bad++; $display("FAIL cont_second got=%0b/%0b/%h exp=1/0/100", busy, owner, req_l2.addr); end
    resp_l2.mem_ready = 1'b1;
    #1;
    total++; if (resp_i.mem_ready !== 1'b1 || resp_d.mem_ready !== 1'b0) begin bad++; $display("FAIL cont_ready2 got=%0b%0b exp=10", resp_i.mem_ready, resp_d.mem_ready); end
    tick();
    drain();
  endtask

  // D writeback then refill while I keeps asking: grants D(store), I, D(load).
  task automatic test_back_to_back();
    int d_ops[$];
    int i_left, gcnt, d_pulses, i_pulses, misroute;
    int got_owner[$];
    int got_op[$];
    logic prev_busy, d_done, i_done, d_gap;
    do_reset();
    d_ops = '{2, 1};
    i_left = 1;
    gcnt = 0; d_pulses = 0; i_pulses = 0; misroute = 0;
    prev_busy = 1'b0; d_gap = 1'b0;
    req_d = mk_req(d_ops[0], 32'h80, 32'hDEAD_BEEF);
    req_i = mk_req(1, 32'h300, 32'h0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (busy && !prev_busy) begin
        got_owner.push_back(int'(owner));
        got_op.push_back(req_l2.mem_req_store ? 2 : 1);
      end
      prev_busy = busy;
      d_done = resp_d.mem_ready;
      i_done = resp_i.mem_ready;
      if (d_done) begin d_pulses++; if (req_l2.addr !== 32'h80) misroute++; end
      if (i_done) begin i_pulses++; if (req_l2.addr !== 32'h300) misroute++; end
      if (req_l2.mem_req_load || req_l2.mem_req_store) gcnt++; else gcnt = 0;
      tick();
      resp_l2.mem_ready = (gcnt == 2);
      if (d_done) begin
        void'(d_ops.pop_front());
        req_d = '0;
        d_gap = 1'b1;
      end else if (d_gap) begin
        d_gap = 1'b0;
        if (d_ops.size() > 0) req_d = mk_req(d_ops[0], 32'h80, 32'h1234_5678);
      end
      if (i_done) begin
        i_left--;
        req_i = '0;
      end
    end
    total++; if (got_owner.size() != 3) begin bad++; $display("FAIL b2b_grants got=%0d exp=3", got_owner.size()); end
    if (got_owner.size() == 3) begin
      total++; if (got_owner[0] != 1 || got_owner[1] != 0 || got_owner[2] != 1) begin bad++; $display("FAIL b2b_order got=%0d%0d%0d exp=101", got_owner[0], got_owner[1], got_owner[2]); end
      total++; if (got_op[0] != 2 || got_op[2] != 1) begin bad++; $display("FAIL b2b_ops got=%0d,%0d exp=2,1", got_op[0], got_op[2]); end
    end
    total++; if (d_pulses != 2 || i_pulses != 1) begin bad++; $display("FAIL b2b_pulses got=%0d/%0d exp=2/1", d_pulses, i_pulses); end
    total++; if (misroute != 0) begin bad++; $display("FAIL b2b_misroute got=%0d exp=0", misroute); end
    total++; if (i_left != 0 || d_ops.size() != 0) begin bad++; $display("FAIL b2b_timeout got=%0d/%0d exp=0/0", i_left, d_ops.size()); end
    drain();
  endtask

  // Reset in GRANT one cycle before L2 would answer.
  task automatic test_reset_in_grant();
    do_reset();
    req_d = mk_req(1, 32'h40, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clock);
    total++; if (req_l2.mem_req_load !== 1'b1) begin bad++; $display("FAIL rig_before got=%0b exp=1", req_l2.mem_req_load); end
    tick();
    reset = 1'b0;
    req_d = '0;
    @(negedge clock);
    total++; if (req_l2.mem_req_load !== 1'b0 || req_l2.mem_req_store !== 1'b0) begin bad++; $display("FAIL rig_req got=%0b%0b exp=00", req_l2.mem_req_load, req_l2.mem_req_store); end
    total++; if (busy !== 1'b0 || owner !== ~TB_RESET_PRIO) begin bad++; $display("FAIL rig_state got=%0b/%0b exp=0/%0b", busy, owner, ~TB_RESET_PRIO); end
`ifdef ARB_STATS_EN
    total++; if (stat_grants_d !== 0) begin bad++; $display("FAIL rig_stats got=%0d exp=0", stat_grants_d); end
`endif
    drain();
  endtask

  // I owns the port and withdraws before ready while D waits.
  task automatic test_abandon();
    logic [2:0] busy_seq;
    do_reset();
    req_i = mk_req(1, 32'h500, 32'h0);
    tick();
    req_d = mk_req(2, 32'h600, 32'h77);
    @(negedge clock);
    total++; if (owner !== 1'b0 || req_l2.addr !== 32'h500) begin bad++; $display("FAIL abn_grant got=%0b/%h exp=0/500", owner, req_l2.addr); end
    tick();
    req_i = '0;
    @(negedge clock);
    total++; if (req_l2.mem_req_load !== 1'b0) begin bad++; $display("FAIL abn_drop got=%0b exp=0", req_l2.mem_req_load); end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clock);
      busy_seq[k] = busy;
    end
    total++; if (busy_seq !== 3'b101) begin bad++; $display("FAIL abn_seq got=%b exp=101", busy_seq); end
    total++; if (owner !== 1'b1 || req_l2.mem_req_store !== 1'b1 || req_l2.addr !== 32'h600) begin bad++; $display("FAIL abn_other got=%0b/%0b/%h exp=1/1/600", owner, req_l2.mem_req_store, req_l2.addr); end
    drain();
  endtask

`ifdef ARB_STATS_EN
  task automatic simple_txn(input logic side);
    if (side) req_d = mk_req(1, 32'h1000, 32'h0);
    else      req_i = mk_req(1, 32'h2000, 32'h0);
    tick();
    resp_l2.mem_ready = 1'b1;
    tick();
    resp_l2.mem_ready = 1'b0;
    req_i = '0;
    req_d = '0;
    tick();
  endtask

  // 5 D and 3 I transactions; I blocked 6 GRANT cycles + 1 RELEASE cycle.
  task automatic test_stats();
    do_reset();
    repeat (4) simple_txn(1'b1);
    repeat (2) simple_txn(1'b0);
    req_d = mk_req(1, 32'h1000, 32'h0);
    req_i = mk_req(1, 32'h2000, 32'h0);
    tick();
    repeat (5) tick();
    resp_l2.mem_ready = 1'b1;
    tick();
    resp_l2.mem_ready = 1'b0;
    req_d = '0;
    tick();
    tick();
    resp_l2.mem_ready = 1'b1;
    tick();
    resp_l2.mem_ready = 1'b0;
    req_i = '0;
    tick();
    @(negedge clock);
    total++; if (stat_grants_d !== 5) begin bad++; $display("FAIL stats_gd got=%0d exp=5", stat_grants_d); end
    total++; if (stat_grants_i !== 3) begin bad++; $display("FAIL stats_gi got=%0d exp=3", stat_grants_i); end
    total++; if (stat_wait !== 7) begin bad++; $display("FAIL stats_wait got=%0d exp=7", stat_wait); end
    drain();
  endtask
`endif

  // Random traffic against a transaction-level model of the port:
  // holder = who has the port (-1 none), cooling = transaction over, port not yet free.
  task automatic test_random();
    int m_hold, m_last, m_gi, m_gd, m_w;
    logic m_cool, a_i, a_d, held;
    int win;
    mem_bus_req_t exp_req;
    logic exp_ri, exp_rd;
    do_reset();
    m_hold = -1; m_cool = 1'b0; m_last = int'(~TB_RESET_PRIO); m_gi = 0; m_gd = 0; m_w = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_i = mk_req($urandom_range(0, 2), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) req_d = mk_req($urandom_range(0, 2), $urandom, $urandom);
      resp_l2.mem_ready = ($urandom_range(0, 2) == 0);
      resp_l2.mem_data = $urandom;
      reset = ($urandom_range(0, 79) == 0);
      @(negedge clock);
      held = (m_hold >= 0) && !m_cool;
      exp_req = held ? ((m_hold == 1) ? req_d : req_i) : '0;
      exp_ri = held && (m_hold == 0) && resp_l2.mem_ready;
      exp_rd = held && (m_hold == 1) && resp_l2.mem_ready;
      total++; if (req_l2 !== exp_req) begin bad++; $display("FAIL rnd_req c=%0d got=%h exp=%h", c, req_l2, exp_req); end
      total++; if (resp_i.mem_ready !== exp_ri || resp_d.mem_ready !== exp_rd) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b%0b exp=%0b%0b", c, resp_i.mem_ready, resp_d.mem_ready, exp_ri, exp_rd); end
      total++; if (busy !== (m_hold >= 0) || owner !== m_last[0]) begin bad++; $display("FAIL rnd_busy_owner c=%0d got=%0b/%0b exp=%0b/%0d", c, busy, owner, m_hold >= 0, m_last); end
`ifdef ARB_STATS_EN
      total++; if (stat_grants_i !== m_gi || stat_grants_d !== m_gd || stat_wait !== m_w) begin bad++; $display("FAIL rnd_stats c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, stat_grants_i, stat_grants_d, stat_wait, m_gi, m_gd, m_w); end
`endif
      // advance the model with the inputs present at the coming edge
      a_i = req_i.mem_req_load | req_i.mem_req_store;
      a_d = req_d.mem_req_load | req_d.mem_req_store;
      if (reset) begin
        m_hold = -1; m_cool = 1'b0; m_last = int'(~TB_RESET_PRIO); m_gi = 0; m_gd = 0; m_w = 0;
      end else begin
        if (m_hold >= 0 && ((m_hold == 1) ? a_i : a_d)) m_w++;
        if (m_hold < 0) begin
          if (a_i || a_d) begin
            win = (a_i && a_d) ? 1 - m_last : (a_d ? 1 : 0);
            m_hold = win;
            m_last = win;
            if (win == 1) m_gd++; else m_gi++;
          end
        end else if (m_cool) begin
          m_hold = -1;
          m_cool = 1'b0;
        end else if (resp_l2.mem_ready || !((m_hold == 1) ? a_d : a_i)) begin
          m_cool = 1'b1;
        end
      end
      tick();
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_d();
    test_contention();
    test_back_to_back();
    test_reset_in_grant();
    test_abandon();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
